// File: rtl/iq_issue.sv
// Issue stage at the consumer end of the instruction queue.
// Picks the longest in-order issuable prefix and registers it as one group.
module iq_issue #(
  parameter type T            = logic [31:0],
  parameter int  EXT_COUNT    = 4,
  parameter int  EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [EXT_COUNT-1:0]    win_valid,
  input  T     [EXT_COUNT-1:0]    win_elements,
  input  logic [EXT_COUNT-1:0]    win_serial,
  output logic                    q_ext_enable,
  output logic [EXTCOUNTLOG2-1:0] q_ext_consumed,
  input  logic                    flush,
  output logic [EXT_COUNT-1:0]    issue_valid,
  output T     [EXT_COUNT-1:0]    issue_elements,
  input  logic                    issue_ready,
  output logic [31:0]             issued_count,
  output logic [15:0]             stall_cycles
);

  localparam int CW = $clog2(EXT_COUNT + 1);

  logic                 occupied;
  logic                 load_ok;
  logic                 consume;
  logic                 stop;
  logic [CW-1:0]        sel_n;
  logic [CW-1:0]        pop;
  logic [EXT_COUNT-1:0] mask;

  assign occupied = |issue_valid;
  assign load_ok  = ~occupied | issue_ready;

  // A serial slot ends the group: alone at slot 0, or deferred later.
  always_comb begin
    sel_n = '0;
    stop  = 1'b0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (!stop) begin
        if (!win_valid[i]) begin
          stop = 1'b1;
        end else if (win_serial[i] && i != 0) begin
          stop = 1'b1;
        end else begin
          sel_n = CW'(i + 1);
          if (win_serial[i]) stop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      mask[i] = (CW'(i) < sel_n);
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      pop = pop + CW'(issue_valid[i]);
    end
  end

  assign consume = load_ok & (sel_n != '0) & ~flush & ~reset;

  always_comb begin
    q_ext_enable   = 1'b0;
    q_ext_consumed = '0;
    if (consume) begin
      q_ext_enable   = 1'b1;
      q_ext_consumed = EXTCOUNTLOG2'(sel_n - CW'(1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_valid  <= '0;
      issued_count <= '0;
      stall_cycles <= '0;
    end else begin
      if (occupied && issue_ready) begin
        issued_count <= issued_count + 32'(pop);
      end
      if (flush) begin
        issue_valid <= '0;
      end else if (consume) begin
        issue_valid <= mask;
      end else if (load_ok) begin
        issue_valid <= '0;
      end
      if (!load_ok && stall_cycles != 16'hFFFF) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

  // Payload carries no reset; it is qualified by issue_valid.
  always_ff @(posedge clock) begin
    if (consume) issue_elements <= win_elements;
  end

endmodule

// File: tb/tb_iq_issue.sv
// Directed bench for iq_issue: selection, handshake, stall, flush, reset.
// Bit i of every slot vector is slot i (slot 0 = oldest).
module tb_iq_issue;

  typedef logic [31:0] elem_t;

  logic              clock;
  logic              reset;
  logic [3:0]        win_valid;
  elem_t [3:0]       win_elements;
  logic [3:0]        win_serial;
  logic              q_ext_enable;
  logic [1:0]        q_ext_consumed;
  logic              flush;
  logic [3:0]        issue_valid;
  elem_t [3:0]       issue_elements;
  logic              issue_ready;
  logic [31:0]       issued_count;
  logic [15:0]       stall_cycles;

  int checks = 0;
  int errors = 0;

  iq_issue #(.T(elem_t), .EXT_COUNT(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .win_valid      (win_valid),
    .win_elements   (win_elements),
    .win_serial     (win_serial),
    .q_ext_enable   (q_ext_enable),
    .q_ext_consumed (q_ext_consumed),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_elements (issue_elements),
    .issue_ready    (issue_ready),
    .issued_count   (issued_count),
    .stall_cycles   (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  elem_t [3:0] grp_a;
  elem_t [3:0] grp_e;
  elem_t [3:0] grp_f;
  elem_t [3:0] grp_g;

  initial begin
    grp_a = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    grp_e = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    grp_f = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
    grp_g = {32'hC3, 32'hC2, 32'hC1, 32'hC0};

    reset        = 1'b1;
    flush        = 1'b0;
    issue_ready  = 1'b1;
    win_valid    = 4'b1111;
    win_serial   = 4'b0000;
    win_elements = grp_a;
    settle();
    chk("reset_no_consume", 128'(q_ext_enable), 128'(1'b0));
    tick();
    chk("reset_valid", 128'(issue_valid), 128'(4'b0000));
    chk("reset_issued", 128'(issued_count), 128'(32'd0));
    chk("reset_stall", 128'(stall_cycles), 128'(16'd0));

    // Full window, no serial
    reset = 1'b0;
    settle();
    chk("full_en", 128'(q_ext_enable), 128'(1'b1));
    chk("full_cnt", 128'(q_ext_consumed), 128'(2'd3));
    tick();
    chk("full_valid", 128'(issue_valid), 128'(4'b1111));
    chk("full_elems", 128'(issue_elements), 128'(grp_a));
    win_valid = 4'b0000;
    settle();
    chk("empty_win_en", 128'(q_ext_enable), 128'(1'b0));
    tick();
    chk("full_issued", 128'(issued_count), 128'(32'd4));
    chk("drain_valid", 128'(issue_valid), 128'(4'b0000));

    // Gap: slots 0,1,3 valid
    win_valid    = 4'b1011;
    win_elements = grp_e;
    settle();
    chk("gap_en", 128'(q_ext_enable), 128'(1'b1));
    chk("gap_cnt", 128'(q_ext_consumed), 128'(2'd1));
    tick();
    chk("gap_valid", 128'(issue_valid), 128'(4'b0011));
    chk("gap_elem0", 128'(issue_elements[0]), 128'(32'hE0));
    chk("gap_elem1", 128'(issue_elements[1]), 128'(32'hE1));
    win_valid = 4'b0000;
    tick();
    chk("gap_issued", 128'(issued_count), 128'(32'd6));

    // Serial on slot 2, then serial at slot 0
    win_valid  = 4'b1111;
    win_serial = 4'b0100;
    settle();
    chk("ser2_en", 128'(q_ext_enable), 128'(1'b1));
    chk("ser2_cnt", 128'(q_ext_consumed), 128'(2'd1));
    tick();
    chk("ser2_valid", 128'(issue_valid), 128'(4'b0011));
    win_serial = 4'b0001;
    settle();
    chk("ser0_en", 128'(q_ext_enable), 128'(1'b1));
    chk("ser0_cnt", 128'(q_ext_consumed), 128'(2'd0));
    tick();
    chk("ser0_valid", 128'(issue_valid), 128'(4'b0001));
    chk("ser0_issued", 128'(issued_count), 128'(32'd8));
    win_valid  = 4'b0000;
    win_serial = 4'b0000;
    tick();
    chk("ser_issued", 128'(issued_count), 128'(32'd9));

    // Slot 0 empty: nothing selected despite later valids
    win_valid = 4'b1110;
    settle();
    chk("hole0_en", 128'(q_ext_enable), 128'(1'b0));
    chk("hole0_cnt", 128'(q_ext_consumed), 128'(2'd0));

    // Hold group for 5 cycles
    win_valid    = 4'b1111;
    win_elements = grp_f;
    tick();
    chk("hold_load", 128'(issue_valid), 128'(4'b1111));
    chk("hold_stall0", 128'(stall_cycles), 128'(16'd0));
    issue_ready  = 1'b0;
    win_elements = grp_g;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("hold_en", 128'(q_ext_enable), 128'(1'b0));
      tick();
      chk("hold_elems", 128'(issue_elements), 128'(grp_f));
    end
    chk("hold_stall", 128'(stall_cycles), 128'(16'd5));
    chk("hold_issued", 128'(issued_count), 128'(32'd9));
    issue_ready = 1'b1;
    settle();
    chk("resume_en", 128'(q_ext_enable), 128'(1'b1));
    chk("resume_cnt", 128'(q_ext_consumed), 128'(2'd3));
    tick();
    chk("resume_elems", 128'(issue_elements), 128'(grp_g));
    chk("resume_issued", 128'(issued_count), 128'(32'd13));
    chk("resume_stall", 128'(stall_cycles), 128'(16'd5));

    // Flush while held with full window
    issue_ready = 1'b0;
    flush       = 1'b1;
    settle();
    chk("flush_en", 128'(q_ext_enable), 128'(1'b0));
    tick();
    chk("flush_valid", 128'(issue_valid), 128'(4'b0000));
    chk("flush_issued", 128'(issued_count), 128'(32'd13));
    flush       = 1'b0;
    issue_ready = 1'b1;

    // Reset pulse mid-stream
    tick();
    chk("pre_rst_valid", 128'(issue_valid), 128'(4'b1111));
    reset = 1'b1;
    settle();
    chk("rst_en", 128'(q_ext_enable), 128'(1'b0));
    tick();
    chk("rst_valid", 128'(issue_valid), 128'(4'b0000));
    chk("rst_issued", 128'(issued_count), 128'(32'd0));
    chk("rst_stall", 128'(stall_cycles), 128'(16'd0));
    reset = 1'b0;
    settle();
    chk("post_rst_en", 128'(q_ext_enable), 128'(1'b1));
    tick();
    chk("post_rst_valid", 128'(issue_valid), 128'(4'b1111));
    win_valid = 4'b0000;
    tick();
    chk("post_rst_issued", 128'(issued_count), 128'(32'd4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
